// File: rtl/rv32_mem_pkg.sv
// Shared load/store definitions for the RV32 data-memory path.
// funct3 encodings, LSU state type and byte-lane helpers.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic logic [3:0] be_mask(
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic [3:0] m;
    if (funct3[1:0] == F3_SB[1:0])
      m = 4'b0001;
    else if (funct3[1:0] == F3_SH[1:0])
      m = 4'b0011;
    else
      m = 4'b1111;
    return m << off;
  endfunction

  function automatic logic is_fault(
    input logic       is_store,
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic ill;
    logic mis;
    ill = is_store ? (funct3 > F3_SW)
                   : (funct3 == 3'd3 || funct3 > F3_LHU);
    mis = (funct3[1:0] == F3_LH[1:0] && off[0]) ||
          (funct3[1:0] == F3_LW[1:0] && off != 2'b00);
    return ill | mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and DMem bundle of the load/store unit.
// slave = the unit, master = core plus data memory.
interface load_store_unit_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic             resp_fault;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_we;
  logic             mem_rd;
  logic [31:0]      mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_funct3,
    input  req_addr, req_wdata, req_tag, mem_rdata,
    output req_ready, resp_valid, resp_data,
    output resp_fault, resp_tag,
    output mem_addr, mem_wdata, mem_we, mem_rd
  );

  modport master (
    output req_valid, req_is_store, req_funct3,
    output req_addr, req_wdata, req_tag, mem_rdata,
    input  req_ready, resp_valid, resp_data,
    input  resp_fault, resp_tag,
    input  mem_addr, mem_wdata, mem_we, mem_rd
  );

endinterface

// File: rtl/lsu_load_align.sv
// Load-data lane shift and sign/zero extension.
// Purely combinational; unused funct3 codes give zero.
module lsu_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    data = '0;
    unique case (1'b1)
      funct3 == F3_LB:  data = {{24{sh[7]}}, sh[7:0]};
      funct3 == F3_LH:  data = {{16{sh[15]}}, sh[15:0]};
      funct3 == F3_LW:  data = sh;
      funct3 == F3_LBU: data = {24'h0, sh[7:0]};
      funct3 == F3_LHU: data = {16'h0, sh[15:0]};
      default:          data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit between execute and DMem.
// One request in flight; faults complete without touching memory.
module load_store_unit
  import rv32_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int TAG_W        = 5
) (
  input  logic clk,
  input  logic rst,
  load_store_unit_if.slave bus
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  lsu_state_t       state;
  lsu_state_t       state_nx;
  logic             accept;
  logic             fault_in;
  logic             last;
  logic             st_q;
  logic             fault_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      data_q;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt;
  logic [31:0]      ld_data;
  logic [31:0]      rep_data;

  assign accept   = bus.req_valid && (state == IDLE);
  assign fault_in = is_fault(bus.req_is_store, bus.req_funct3,
                             bus.req_addr[1:0]);
  assign last     = (cnt == CW'(READ_LATENCY - 1));

  lsu_load_align u_align (
    .rdata  (bus.mem_rdata),
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = fault_in ? RESP : ISSUE;
      ISSUE:   state_nx = st_q ? RESP : WAIT;
      WAIT:    if (last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        st_q    <= bus.req_is_store;
        fault_q <= fault_in;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        tag_q   <= bus.req_tag;
        data_q  <= '0;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && !last)
        cnt <= cnt + 1'b1;
      // rdata is already lane-shifted and extended here
      if (state == WAIT && last)
        data_q <= ld_data;
    end
  end

  always_comb begin
    rep_data = wdata_q;
    if (f3_q[1:0] == F3_SB[1:0])
      rep_data = {4{wdata_q[7:0]}};
    else if (f3_q[1:0] == F3_SH[1:0])
      rep_data = {2{wdata_q[15:0]}};
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.resp_fault = 1'b0;
    bus.resp_tag   = '0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_we     = '0;
    bus.mem_rd     = 1'b0;
    unique case (state)
      IDLE: bus.req_ready = 1'b1;
      ISSUE: begin
        bus.mem_addr = {addr_q[31:2], 2'b00};
        if (st_q) begin
          bus.mem_we    = be_mask(f3_q, addr_q[1:0]);
          bus.mem_wdata = rep_data;
        end else begin
          bus.mem_rd = 1'b1;
        end
      end
      WAIT: begin
        bus.mem_addr = {addr_q[31:2], 2'b00};
        bus.mem_rd   = 1'b1;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = data_q;
        bus.resp_fault = fault_q;
        bus.resp_tag   = tag_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic
// against a byte-addressed reference memory.
module tb_load_store_unit;

  localparam int RL = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  load_store_unit_if #(.TAG_W(5)) bus ();

  load_store_unit #(
    .READ_LATENCY (RL),
    .TAG_W        (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMem model: word array, one-cycle synchronous read
  logic [31:0] dmem [logic [29:0]];

  function automatic logic [31:0] dm_rd(input logic [29:0] idx);
    if (dmem.exists(idx)) return dmem[idx];
    if (idx == 30'h0004_0000) return 32'h1387_4751;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    if (bus.mem_rd)
      bus.mem_rdata <= dm_rd(bus.mem_addr[31:2]);
    if (bus.mem_we != 4'b0000) begin
      w = dm_rd(bus.mem_addr[31:2]);
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
      dmem[bus.mem_addr[31:2]] = w;
    end
  end

  // Reference model: byte-granular memory
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    logic [31:0] init;
    init = 32'h1387_4751;
    if (ref_mem.exists(a)) return ref_mem[a];
    if (a[31:2] == 30'h0004_0000) return init[8*a[1:0] +: 8];
    return 8'h0;
  endfunction

  task automatic check(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", nm, obs, exp);
  endtask

  task automatic run_req(
    input  logic        st,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [4:0]  tg,
    output logic [31:0] got_data,
    output logic [3:0]  got_we,
    output logic [31:0] got_wd
  );
    int          nb;
    int          k;
    int          lat;
    logic        flt;
    logic [31:0] exp_d;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic        rd_seen;
    if (st) flt = (f3 >= 3);
    else    flt = (f3 == 3 || f3 >= 6);
    nb = 1 << f3[1:0];
    if (nb == 2 && a % 2 != 0) flt = 1'b1;
    if (nb == 4 && a % 4 != 0) flt = 1'b1;
    exp_d  = 0;
    exp_we = 0;
    exp_wd = 0;
    if (!flt && !st) begin
      for (int i = 0; i < nb; i++)
        exp_d = exp_d + (32'(ref_rd(a + i)) << (8 * i));
      if (f3 < 4 && nb < 4 && exp_d[8*nb-1])
        exp_d = exp_d | ~((32'd1 << (8 * nb)) - 1);
    end
    if (!flt && st) begin
      for (int i = 0; i < nb; i++)
        exp_we[(a % 4) + i] = 1'b1;
      for (int j = 0; j < 4; j++)
        exp_wd[8*j +: 8] = wd[8*(j % nb) +: 8];
    end
    lat = flt ? 1 : (st ? 2 : 2 + RL);

    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_tag      = tg;
    bus.req_valid    = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 1;
    got_we  = 0;
    got_wd  = 0;
    rd_seen = 0;
    while (!bus.resp_valid && k < 30) begin
      got_we  = got_we | bus.mem_we;
      rd_seen = rd_seen | bus.mem_rd;
      if (bus.mem_we != 0) got_wd = bus.mem_wdata;
      @(negedge clk);
      k++;
    end
    got_data = bus.resp_data;
    check("latency", 32'(k), 32'(lat));
    check("resp_fault", 32'(bus.resp_fault), 32'(flt));
    check("resp_data", bus.resp_data, exp_d);
    check("resp_tag", 32'(bus.resp_tag), 32'(tg));
    check("mem_we", 32'(got_we), 32'(exp_we));
    check("mem_rd", 32'(rd_seen), 32'(!flt && !st));
    if (exp_we != 0) check("mem_wdata", got_wd, exp_wd);
    @(negedge clk);
    check("pulse_end", 32'(bus.resp_valid), 32'd0);
    check("ready_back", 32'(bus.req_ready), 32'd1);
    if (!flt && st)
      for (int i = 0; i < nb; i++)
        ref_mem[a + i] = wd[8*i +: 8];
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  we;
    logic [31:0] wdo;
    int          n;
    logic        seen;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_tag      = '0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp", 32'(bus.resp_valid), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_req(0, 3'd2, 32'h0010_0000, 0, 5'd1, d, we, wdo);
    check("lw_init", d, 32'h1387_4751);
    run_req(1, 3'd0, 32'h8000_0002, 32'hA5, 5'd2, d, we, wdo);
    check("sb_we", 32'(we), 32'h4);
    check("sb_wdata", wdo, 32'hA5A5_A5A5);
    run_req(0, 3'd0, 32'h8000_0002, 0, 5'd3, d, we, wdo);
    check("lb", d, 32'hFFFF_FFA5);
    run_req(0, 3'd4, 32'h8000_0002, 0, 5'd4, d, we, wdo);
    check("lbu", d, 32'h0000_00A5);
    run_req(1, 3'd1, 32'h8000_0006, 32'h8001, 5'd5, d, we, wdo);
    check("sh_we", 32'(we), 32'hC);
    run_req(0, 3'd1, 32'h8000_0006, 0, 5'd6, d, we, wdo);
    check("lh", d, 32'hFFFF_8001);
    run_req(0, 3'd5, 32'h8000_0006, 0, 5'd7, d, we, wdo);
    check("lhu", d, 32'h0000_8001);
    run_req(0, 3'd2, 32'h8000_0004, 0, 5'd8, d, we, wdo);
    check("lw_upper", 32'(d[31:16]), 32'h8001);
    run_req(0, 3'd2, 32'h8000_0001, 0, 5'd9, d, we, wdo);
    run_req(1, 3'd1, 32'h8000_0003, 32'hFFFF, 5'd10, d, we, wdo);
    run_req(0, 3'd2, 32'h8000_0000, 0, 5'd11, d, we, wdo);
    check("fault_nowrite", d, 32'h00A5_0000);

    // Second request held during the first one's wait
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'd2;
    bus.req_addr     = 32'h8000_0004;
    bus.req_tag      = 5'd3;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_addr = 32'h8000_0000;
    bus.req_tag  = 5'd7;
    n = 0;
    seen = 1'b0;
    while (!bus.resp_valid && n < 30) begin
      seen = seen | bus.req_ready;
      @(negedge clk);
      n++;
    end
    check("busy_ready", 32'(seen), 32'd0);
    check("tag_first", 32'(bus.resp_tag), 32'd3);
    @(negedge clk);
    check("ready_after", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("tag_second", 32'(bus.resp_tag), 32'd7);
    @(negedge clk);

    // Reset asserted while waiting on read data
    bus.req_addr  = 32'h8000_0004;
    bus.req_tag   = 5'd9;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("wait_rd", 32'(bus.mem_rd), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_rd", 32'(bus.mem_rd), 32'd0);
    check("abort_addr", bus.mem_addr, 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | bus.resp_valid;
    end
    check("abort_noresp", 32'(seen), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_req(0, 3'd2, 32'h8000_0004, 0, 5'd12, d, we, wdo);

    for (int i = 0; i < 40; i++) begin
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'h8000_0000 + $urandom_range(0, 31), $urandom,
              5'($urandom_range(0, 31)), d, we, wdo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
